// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: action selector and
// step-alignment helper.
package pc_pkg;

   typedef enum logic [2:0] {
      RESET,
      TRAP,
      STALL,
      RET,
      CALL,
      BRANCH,
      SEQ
   } pc_act_e;

   // STEP is a power of two between 1 and 16, so a short scan covers every legal value
   function automatic int step_log2(input int step);
      int n;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         if ((1 << i) == step) n = i;
      end
      return n;
   endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest
// entry, and a pop from an empty stack leaves the stack unchanged; both raise err.
module pc_ras #(
   parameter int WIDTH     = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full,
   output logic             err
);

   localparam int            PW       = $clog2(RAS_DEPTH);
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(RAS_DEPTH);

   logic [WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW:0]      depth_q, depth_d;
   logic             err_q, err_d;
   logic [PW-1:0]    top_idx;

   // ptr_q is the next free slot; it wraps naturally because RAS_DEPTH is a power of two
   always_comb begin
      ptr_d   = ptr_q;
      depth_d = depth_q;
      err_d   = 1'b0;
      if (pop) begin
         if (depth_q == '0) begin
            err_d = 1'b1;
         end else begin
            ptr_d   = ptr_q - PW'(1);
            depth_d = depth_q - (PW+1)'(1);
         end
      end else if (push) begin
         ptr_d = ptr_q + PW'(1);
         if (depth_q == FULL_CNT) err_d = 1'b1;
         else                     depth_d = depth_q + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q   <= '0;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && push && !pop) mem_q[ptr_q] <= push_data;
   end

   assign top_idx = ptr_q - PW'(1);
   assign top     = mem_q[top_idx];
   assign empty   = (depth_q == '0);
   assign full    = (depth_q == FULL_CNT);
   assign err     = err_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: priority action decode, target alignment and the
// count register, with a return-address stack for call/ret.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter int               STEP      = 4,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter logic [WIDTH-1:0] TRAP_VEC  = 'h80,
   parameter int               RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             trap,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             call,
   input  logic [WIDTH-1:0] call_target,
   input  logic             ret,
   output logic [WIDTH-1:0] count,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_err
);

   localparam int               STEP_LG    = step_log2(STEP);
   localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << STEP_LG;
   localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

   pc_act_e          act;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] ras_top;
   logic             ras_push, ras_pop;

   assign seq_pc = count_q + STEP_W;

   always_comb begin
      act = SEQ;
      if (!reset)            act = RESET;
      else if (trap)         act = TRAP;
      else if (stall)        act = STALL;
      else if (ret)          act = RET;
      else if (call)         act = CALL;
      else if (branch_taken) act = BRANCH;
   end

   // An underflowing ret falls through to the sequential address; the stack flags the error
   always_comb begin
      count_d  = count_q;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      unique case (act)
         RESET:   count_d = RESET_VEC;
         TRAP:    count_d = TRAP_VEC;
         STALL:   count_d = count_q;
         RET: begin
            ras_pop = 1'b1;
            count_d = ras_empty ? seq_pc : ras_top;
         end
         CALL: begin
            ras_push = 1'b1;
            count_d  = call_target & ALIGN_MASK;
         end
         BRANCH:  count_d = branch_target & ALIGN_MASK;
         default: count_d = seq_pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) count_q <= RESET_VEC;
      else        count_q <= count_d;
   end

   pc_ras #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (seq_pc),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .err       (ras_err)
   );

   assign count = count_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: program counter width in bits.
REQ-002 Parameter STEP, default 4: sequential increment; power of two, 1 to 16.
REQ-003 Parameter RESET_VEC, default 0: count value loaded by reset.
REQ-004 Parameter TRAP_VEC, default 32'h80: count value loaded by trap.
REQ-005 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, 2 to 16.
REQ-006 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-007 Port reset, input, 1: synchronous, active-low reset.
REQ-008 Port stall, input, 1: freeze count and stack.
REQ-009 Port trap, input, 1: redirect to TRAP_VEC.
REQ-010 Port branch_taken, input, 1: load branch_target.
REQ-011 Port branch_target, input, WIDTH: branch destination.
REQ-012 Port call, input, 1: push return address and load call_target.
REQ-013 Port call_target, input, WIDTH: call destination.
REQ-014 Port ret, input, 1: pop the stack into count.
REQ-015 Port count, output, WIDTH: current program counter (registered).
REQ-016 Port ras_empty, output, 1: stack holds 0 entries.
REQ-017 Port ras_full, output, 1: stack holds RAS_DEPTH entries.
REQ-018 Port ras_err, output, 1: one-cycle pulse on stack overflow or underflow.

Function
REQ-019 All inputs are sampled on the rising edge; count shows the new value one cycle later (latency 1).
REQ-020 When reset is high, exactly one action is taken per edge, by priority: trap > stall > ret > call > branch_taken > sequential.
REQ-021 Trap: count <= TRAP_VEC; stack unchanged; trap overrides stall.
REQ-022 Stall, with no trap: count, stack pointer and stack contents hold; ras_err = 0.
REQ-023 Sequential: count <= count + STEP, modulo 2^WIDTH; wrap from all-ones-minus-STEP+1 to 0 is legal and silent.
REQ-024 Branch: count <= branch_target with its low log2(STEP) bits forced to 0.
REQ-025 Call: push (count + STEP) mod 2^WIDTH, and count <= aligned call_target.
REQ-026 Call when full: the oldest entry is overwritten (circular stack); depth stays RAS_DEPTH; ras_err pulses.
REQ-027 Ret when not empty: count <= top entry; depth decrements.
REQ-028 Ret when empty: treated as sequential (count + STEP); ras_err pulses.
REQ-029 Call and ret asserted together: ret wins; no push.
REQ-030 ras_empty and ras_full are registered and reflect the depth after the current edge.
REQ-031 ras_err is registered, high for exactly one cycle per error event, else 0.

Reset
REQ-032 When reset is low at a rising edge, all other inputs are ignored.
REQ-033 On such an edge: count <= RESET_VEC; depth <= 0; ras_empty = 1; ras_full = 0; ras_err = 0.
REQ-034 Stack entry contents are not reset, and are never observable while empty.
REQ-035 Reset mid-call-sequence discards all pending return addresses; the first ret after reset underflows.

Structure
REQ-036 Shared package pc_pkg holds:
- the action-select enumeration: RESET, TRAP, STALL, RET, CALL, BRANCH, SEQ;
- the function computing log2(STEP).
REQ-037 The return-address stack is sub-module pc_ras, which:
- is parametrised by WIDTH and RAS_DEPTH;
- takes push, pop and push_data;
- outputs top, empty, full and err.
REQ-038 pc_sequencer contains only the priority decode, the alignment logic and the count register.

Verification (WIDTH=32, STEP=4, RESET_VEC=0, TRAP_VEC=0x80, RAS_DEPTH=4)
REQ-039 Reset low for 3 cycles, then high for 3 idle cycles -> count 0, 0, 0, then 4, 8, 0xC; ras_empty = 1 throughout.
REQ-040 Stall held 2 cycles at count 0x10 -> count stays 0x10; release -> 0x14; trap during stall -> 0x80.
REQ-041 Branch with branch_target 0x103 at count 0x20 -> count 0x100, then 0x104.
REQ-042 Call sequence:
- call to 0x200 at count 0x40 -> count 0x200, stack top 0x44;
- ret -> count 0x44, ras_empty = 1;
- a second ret -> count 0x48 and ras_err pulses.
REQ-043 Overflow and wrap:
- 5 successive calls from counts A..E -> ras_err pulses on the 5th, ras_full = 1;
- 4 rets return E+4, D+4, C+4, B+4;
- count 0xFFFFFFFC sequential -> 0x0.
REQ-044 Reset low mid-stack after 2 calls -> count 0, ras_empty = 1; the next ret -> count 4 with a ras_err pulse.
